math_unit_seq: RTL and testbench

MATH_UNIT_SEQ -- requirements
Module: math_unit_seq

---
 rtl/math_unit_seq.sv | 185 ++++++++++++++++++
 tb/tb_math_unit_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/math_unit_seq.sv
// -----------------------------------------------------------------------------
// math_unit_seq
//
// Small sequential arithmetic unit with valid/ready handshakes on both sides.
// Add, subtract and pass-a complete in a single cycle; multiply (optional) is an
// unsigned shift-add that retires one multiplier bit per cycle.
//
// Build option:
//   MATH_UNIT_SEQ_MUL_EN  when defined, op=10 runs the iterative multiplier and
//                         the MUL state exists. When undefined, op=10 behaves
//                         exactly like pass-a and no multiplier logic is built.
//
// Parameters:
//   WIDTH      operand width in bits (4..32)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present
//   in_ready   unit can accept a request (combinational from out_ready in DONE)
//   op         00 add, 01 sub, 10 mul, 11 pass-a
//   a, b       operands, captured on the acceptance edge
//   out_valid  result present
//   out_ready  consumer takes the result
//   result     low result word
//   result_hi  high product word (0 for non-mul operations)
//   flags      {carry, overflow, zero, negative}
// -----------------------------------------------------------------------------
module math_unit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;

`ifdef MATH_UNIT_SEQ_MUL_EN
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int         CNT_W  = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_e;
`endif

  state_e           state_q;
  logic             outValid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] resultHi_q;
  logic [3:0]       flags_q;

  logic             accept;
  logic [WIDTH-1:0] bOperand;
  logic [WIDTH:0]   addSum;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;

  // A finished result can be retired and replaced on the same edge, so the
  // unit is ready in DONE whenever the consumer is taking the current result.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle datapath, evaluated on the live inputs so that the acceptance
  // edge captures the finished result directly.
  // Subtraction is a + ~b + 1; the carry-out is then "no borrow".
  always_comb begin
    bOperand = (op == OP_SUB) ? ~b : b;
    addSum   = {1'b0, a} + {1'b0, bOperand} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    result_d = a;
    flags_d  = 4'b0000;
    if ((op == OP_ADD) || (op == OP_SUB)) begin
      result_d   = addSum[WIDTH-1:0];
      flags_d[3] = addSum[WIDTH];
      // Signed overflow: both addends share a sign that the sum does not.
      flags_d[2] = (a[WIDTH-1] == bOperand[WIDTH-1]) &&
                   (addSum[WIDTH-1] != a[WIDTH-1]);
    end
    flags_d[1] = (result_d == '0);
    flags_d[0] = result_d[WIDTH-1];
  end

`ifdef MATH_UNIT_SEQ_MUL_EN
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] accum_q;
  logic [CNT_W-1:0]   count_q;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] accum_d;
  logic [3:0]         mulFlags_d;

  // The accumulator holds {partial product, remaining multiplier bits}. Each
  // step conditionally adds the multiplicand into the upper half and shifts
  // the whole thing right by one; after WIDTH steps it holds the product.
  always_comb begin
    mulSum     = {1'b0, accum_q[2*WIDTH-1:WIDTH]} +
                 (accum_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    accum_d    = {mulSum, accum_q[WIDTH-1:1]};
    mulFlags_d = {2'b00, (accum_d == '0), accum_d[2*WIDTH-1]};
  end
`endif

  // Control FSM with registered outputs. A new request always wins over the
  // per-state behaviour because acceptance is only possible in IDLE or in
  // DONE while the current result is being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      outValid_q <= 1'b0;
      result_q   <= '0;
      resultHi_q <= '0;
      flags_q    <= '0;
`ifdef MATH_UNIT_SEQ_MUL_EN
      mcand_q    <= '0;
      accum_q    <= '0;
      count_q    <= '0;
`endif
    end else if (accept) begin
`ifdef MATH_UNIT_SEQ_MUL_EN
      if (op == OP_MUL) begin
        state_q    <= MUL;
        outValid_q <= 1'b0;
        mcand_q    <= a;
        accum_q    <= {{WIDTH{1'b0}}, b};
        count_q    <= '0;
      end else
`endif
      begin
        state_q    <= DONE;
        outValid_q <= 1'b1;
        result_q   <= result_d;
        resultHi_q <= '0;
        flags_q    <= flags_d;
      end
    end else begin
      case (state_q)
`ifdef MATH_UNIT_SEQ_MUL_EN
        MUL: begin
          accum_q <= accum_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == CNT_W'(WIDTH-1)) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            result_q   <= accum_d[WIDTH-1:0];
            resultHi_q <= accum_d[2*WIDTH-1:WIDTH];
            flags_q    <= mulFlags_d;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign result    = result_q;
  assign result_hi = resultHi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_math_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_math_unit_seq
//
// Directed bench for math_unit_seq at WIDTH=8. Each request pushes its
// hand-computed response onto a queue; an independent monitor compares every
// presented output against the queue head (values and latency) and pops it
// when the consumer takes it. Works with or without MATH_UNIT_SEQ_MUL_EN.
// -----------------------------------------------------------------------------
module tb_math_unit_seq;

  localparam int W = 8;

`ifdef MATH_UNIT_SEQ_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;

  int checks     = 0;
  int errors     = 0;
  int cycleCount = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic [3:0]   flg;
    int           acceptCycle;
    int           latency;
    string        name;
  } expect_t;

  expect_t expQ[$];
  expect_t head;
  bit      headSeen = 1'b0;

  math_unit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  // 10 time-unit clock; outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Rising-edge counter used to measure request latency.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Drive one request, wait (bounded) for the acceptance edge, optionally
  // queue the expected response, then scramble the inputs.
  task automatic applyStimulus(input string name, input logic [1:0] opIn,
                               input logic [W-1:0] aIn, input logic [W-1:0] bIn,
                               input logic [W-1:0] expRes, input logic [W-1:0] expHi,
                               input logic [3:0] expFlags, input int expLat,
                               input bit track);
    bit accepted = 1'b0;
    in_valid = 1'b1;
    op       = opIn;
    a        = aIn;
    b        = bIn;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checkOutput({name, " accept timeout"}, in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (track) expQ.push_back('{expRes, expHi, expFlags, cycleCount + 1, expLat, name});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 2'($urandom);
    a        = W'($urandom);
    b        = W'($urandom);
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 100; i++) begin
      if (expQ.size() == 0) break;
      @(negedge clk);
    end
    checkOutput({name, " drain"}, expQ.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented output must match the queue head; the first
  // cycle it appears also checks latency from the acceptance edge.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected out_valid actual=1 required=0 result=0x%0h", result);
        end else begin
          head = expQ[0];
          if (!headSeen) begin
            checkOutput({head.name, " latency"}, cycleCount - head.acceptCycle + 1,
                        head.latency);
            headSeen = 1'b1;
          end
          checkOutput({head.name, " result"}, result, head.res);
          checkOutput({head.name, " result_hi"}, result_hi, head.hi);
          checkOutput({head.name, " flags"}, flags, head.flg);
          if (out_ready) begin
            void'(expQ.pop_front());
            headSeen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    #2;
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset result", result, 0);
    checkOutput("reset result_hi", result_hi, 0);
    checkOutput("reset flags", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle operations; flags are {C,V,Z,N}.
    applyStimulus("add 7F+01", 2'b00, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0101, 1, 1'b1);
    applyStimulus("sub 05-05", 2'b01, 8'h05, 8'h05, 8'h00, 8'h00, 4'b1010, 1, 1'b1);
    applyStimulus("sub 00-01", 2'b01, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus("add FF+01", 2'b00, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1010, 1, 1'b1);
    applyStimulus("add 80+80", 2'b00, 8'h80, 8'h80, 8'h00, 8'h00, 4'b1110, 1, 1'b1);
    applyStimulus("pass 9A", 2'b11, 8'h9A, 8'h11, 8'h9A, 8'h00, 4'b0001, 1, 1'b1);
    applyStimulus("sub 80-01", 2'b01, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1100, 1, 1'b1);

`ifdef MATH_UNIT_SEQ_MUL_EN
    applyStimulus("mul FF*FF", 2'b10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0001, MUL_LAT, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput("mul busy in_ready", in_ready, 0);
      checkOutput("mul busy out_valid", out_valid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus("mul 0D*0B", 2'b10, 8'h0D, 8'h0B, 8'h8F, 8'h00, 4'b0000, MUL_LAT, 1'b1);
    applyStimulus("mul 00*37", 2'b10, 8'h00, 8'h37, 8'h00, 8'h00, 4'b0010, MUL_LAT, 1'b1);
    applyStimulus("mul 80*02", 2'b10, 8'h80, 8'h02, 8'h00, 8'h01, 4'b0000, MUL_LAT, 1'b1);
    applyStimulus("op10 3C,02", 2'b10, 8'h3C, 8'h02, 8'h78, 8'h00, 4'b0000, MUL_LAT, 1'b1);
`else
    applyStimulus("op10 FF,FF", 2'b10, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0001, MUL_LAT, 1'b1);
    applyStimulus("op10 3C,02", 2'b10, 8'h3C, 8'h02, 8'h3C, 8'h00, 4'b0000, MUL_LAT, 1'b1);
`endif

    // Consumer stalls for five cycles, then takes the result while a new
    // request arrives on the same edge.
    waitDrain("pre-stall");
    out_ready = 1'b0;
    applyStimulus("add 11+22 held", 2'b00, 8'h11, 8'h22, 8'h33, 8'h00, 4'b0000, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall in_ready", in_ready, 0);
      checkOutput("stall out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus("add 01+01 b2b", 2'b00, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1, 1'b1);
    @(negedge clk);
    checkOutput("b2b out_valid", out_valid, 1);
    checkOutput("b2b result", result, 8'h02);

    // Reset in the middle of an operation: everything clears at once and the
    // aborted request never produces a result.
    waitDrain("pre-reset");
`ifdef MATH_UNIT_SEQ_MUL_EN
    applyStimulus("mul aborted", 2'b10, 8'h12, 8'h34, 8'h00, 8'h00, 4'b0000, MUL_LAT, 1'b0);
    repeat (3) @(posedge clk);
`else
    out_ready = 1'b0;
    applyStimulus("add aborted", 2'b00, 8'h12, 8'h34, 8'h46, 8'h00, 4'b0000, 1, 1'b1);
    repeat (2) @(posedge clk);
`endif
    #2;
    rst_n = 1'b0;
    expQ.delete();
    headSeen = 1'b0;
    #1;
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort result", result, 0);
    checkOutput("abort result_hi", result_hi, 0);
    checkOutput("abort flags", flags, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("post-abort out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    applyStimulus("add 03+04 after reset", 2'b00, 8'h03, 8'h04, 8'h07, 8'h00, 4'b0000, 1, 1'b1);

    waitDrain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
